// File: rtl/msg_packer.sv
// Round-robin message packer: pops the granted channel's slave FIFO one byte at a
// time and frames it as SYNC, ADDR, LEN, payload, CSUM on a valid/ready byte stream.
module msg_packer #(
  parameter int         NUM_CH    = 5,
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic                  sys_clk,
  input  logic                  n_rst,
  input  logic [NUM_CH-1:0]     have_msg_bus,
  input  logic [8*NUM_CH-1:0]   len_bus,
  input  logic [8*NUM_CH-1:0]   slave_data_bus,
  output logic [NUM_CH-1:0]     rdreq_bus,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  typedef enum logic [2:0] {
    IDLE, SYNC, ADDR, LEN, FETCH, CAPT, DATA, CSUM
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   ch;
  logic [7:0]        len_q;
  logic [7:0]        remaining;
  logic [7:0]        csum;

  logic [7:0]        len_arr  [NUM_CH];
  logic [7:0]        data_arr [NUM_CH];
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   scan_idx;
  logic [7:0]        grant_len;
  logic              accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign len_arr[g]  = len_bus[8*g +: 8];
    assign data_arr[g] = slave_data_bus[8*g +: 8];
  end

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  assign accept    = tx_valid & tx_ready;
  assign grant_len = len_arr[grant_ch];

  // Scan upward from rr_ptr with wrap; the first pending channel wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_valid = 1'b0;
    grant_ch    = rr_ptr;
    scan_idx    = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_valid && have_msg_bus[scan_idx]) begin
        grant_valid = 1'b1;
        grant_ch    = scan_idx;
      end
      scan_idx = next_ch(scan_idx);
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ch        <= '0;
      len_q     <= '0;
      remaining <= '0;
      csum      <= '0;
      rdreq_bus <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      rdreq_bus <= '0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            ch    <= grant_ch;
            len_q <= grant_len;
            if (grant_len == 8'd0) begin
              rr_ptr <= next_ch(grant_ch);
            end else begin
              busy     <= 1'b1;
              tx_data  <= SYNC_BYTE;
              tx_valid <= 1'b1;
              csum     <= '0;
              state    <= SYNC;
            end
          end
        end
        SYNC: begin
          if (accept) begin
            tx_data <= BASE_ADDR + 8'(ch);
            csum    <= BASE_ADDR + 8'(ch);
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (accept) begin
            tx_data <= len_q;
            csum    <= csum + len_q;
            state   <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            tx_valid  <= 1'b0;
            remaining <= len_q;
            rdreq_bus <= ONE_HOT0 << ch;
            state     <= FETCH;
          end
        end
        // The pop issued on entry is in flight; the FIFO q is valid next cycle.
        FETCH: state <= CAPT;
        CAPT: begin
          tx_data   <= data_arr[ch];
          tx_valid  <= 1'b1;
          csum      <= csum + data_arr[ch];
          remaining <= remaining - 8'd1;
          state     <= DATA;
        end
        DATA: begin
          if (accept) begin
            if (remaining != 8'd0) begin
              tx_valid  <= 1'b0;
              rdreq_bus <= ONE_HOT0 << ch;
              state     <= FETCH;
            end else begin
              tx_data <= csum;
              state   <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            rr_ptr   <= next_ch(ch);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rdreq_onehot: assert property (@(posedge sys_clk) disable iff (!n_rst)
    $onehot0(rdreq_bus));

  a_tx_hold: assert property (@(posedge sys_clk) disable iff (!n_rst)
    (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));

endmodule

// File: tb/tb_msg_packer.sv
// Randomized scoreboard bench for msg_packer: FIFO-backed channel models, a packet-level
// reference model feeding an expected-byte queue, and a negedge monitor that checks the stream.
module tb_msg_packer;

  localparam int         NUM_CH    = 5;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] BASE_ADDR = 8'h10;

  logic                  sys_clk = 1'b0;
  logic                  n_rst   = 1'b1;
  logic [NUM_CH-1:0]     have_msg_bus = '0;
  logic [8*NUM_CH-1:0]   len_bus = '0;
  logic [8*NUM_CH-1:0]   slave_data_bus = '0;
  logic [NUM_CH-1:0]     rdreq_bus;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready = 1'b0;
  logic                  busy;

  msg_packer #(
    .NUM_CH   (NUM_CH),
    .SYNC_BYTE(SYNC_BYTE),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .sys_clk       (sys_clk),
    .n_rst         (n_rst),
    .have_msg_bus  (have_msg_bus),
    .len_bus       (len_bus),
    .slave_data_bus(slave_data_bus),
    .rdreq_bus     (rdreq_bus),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int                n_tests = 0;
  int                n_fail  = 0;

  logic [7:0]        fifo [NUM_CH][$];
  logic [7:0]        sdata [NUM_CH];
  logic [NUM_CH-1:0] force_have   = '0;
  logic [NUM_CH-1:0] force_len_en = '0;
  logic [7:0]        force_len [NUM_CH];
  int                pop_cnt  [NUM_CH];
  int                exp_pops [NUM_CH];

  logic [7:0]        exp_q[$];
  int                rd_idx = 0;
  logic [NUM_CH-1:0] pop_req = '0;
  logic              prev_stall = 1'b0;
  logic [7:0]        prev_data = '0;
  int                rr_m = 0;
  int                rdy_prob = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, so tx_valid & tx_ready seen here transfer on the next edge.
  always @(negedge sys_clk) begin
    if (!n_rst) begin
      pop_req    = '0;
      prev_stall = 1'b0;
    end else begin
      pop_req = rdreq_bus;
      if (rdreq_bus != '0) check("rdreq_onehot", $countones(rdreq_bus), 1);
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1'b1);
        check("stall_data_stable", tx_data, prev_data);
      end
      if (tx_valid) check("busy_with_valid", busy, 1'b1);
      if (tx_valid && tx_ready) begin
        if (rd_idx < exp_q.size())
          check($sformatf("tx_byte[%0d]", rd_idx), tx_data, exp_q[rd_idx]);
        else
          check("tx_extra_byte_index", rd_idx, exp_q.size());
        rd_idx++;
        prev_stall = 1'b0;
      end else begin
        prev_stall = tx_valid;
        prev_data  = tx_data;
      end
    end
  end

  task automatic update_bus();
    for (int k = 0; k < NUM_CH; k++) begin
      int sz;
      sz = fifo[k].size();
      have_msg_bus[k]     = force_have[k] || (sz != 0);
      len_bus[8*k +: 8]   = force_len_en[k] ? force_len[k] : ((sz > 255) ? 8'd255 : 8'(sz));
      slave_data_bus[8*k +: 8] = sdata[k];
    end
  endtask

  // One clock: show-ahead-off FIFOs pop on the edge after a sampled rdreq.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pop_req[k]) begin
        check($sformatf("pop_nonempty_ch%0d", k), fifo[k].size() != 0, 1'b1);
        if (fifo[k].size() != 0) begin
          sdata[k] = fifo[k].pop_front();
          pop_cnt[k]++;
        end
      end
    end
    update_bus();
    tx_ready = ($urandom_range(99) < rdy_prob);
  endtask

  task automatic reset_dut();
    n_rst = 1'b0;
    #1;
    check("rst_rdreq", rdreq_bus, '0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      fifo[k].delete();
      sdata[k]     = '0;
      force_len[k] = '0;
      pop_cnt[k]   = 0;
      exp_pops[k]  = 0;
    end
    force_have   = '0;
    force_len_en = '0;
    tx_ready     = 1'b0;
    update_bus();
    tick();
    tick();
    n_rst = 1'b1;
    rr_m  = 0;
  endtask

  task automatic load(input int k, input int n, input bit rand_bytes, input logic [7:0] val);
    for (int j = 0; j < n; j++)
      fifo[k].push_back(rand_bytes ? 8'($urandom_range(255)) : val);
  endtask

  // Packet-level model: grant order, length snapshot and checksum from the channel rules.
  task automatic model_drain();
    logic [7:0] mq [NUM_CH][$];
    for (int c = 0; c < NUM_CH; c++) mq[c] = fifo[c];
    for (int guard = 0; guard < 1000; guard++) begin
      bit         hv [NUM_CH];
      int         ln [NUM_CH];
      bit         work;
      int         k;
      logic [7:0] sum;
      logic [7:0] b;
      work = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        hv[c] = force_have[c] || (mq[c].size() != 0);
        ln[c] = force_len_en[c] ? int'(force_len[c]) : ((mq[c].size() > 255) ? 255 : mq[c].size());
        if (hv[c] && ln[c] != 0) work = 1'b1;
      end
      if (!work) break;
      k = rr_m;
      while (!hv[k]) k = (k + 1) % NUM_CH;
      rr_m = (k + 1) % NUM_CH;
      if (ln[k] == 0) continue;
      exp_q.push_back(SYNC_BYTE);
      exp_q.push_back(BASE_ADDR + 8'(k));
      exp_q.push_back(8'(ln[k]));
      sum = BASE_ADDR + 8'(k) + 8'(ln[k]);
      for (int j = 0; j < ln[k]; j++) begin
        b = mq[k].pop_front();
        exp_q.push_back(b);
        sum = sum + b;
      end
      exp_q.push_back(sum);
      exp_pops[k] += ln[k];
    end
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (!(rd_idx == exp_q.size() && !busy && !tx_valid) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("drain_within_budget", cyc < budget, 1'b1);
    repeat (6) tick();
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("pops_ch%0d", k), pop_cnt[k], exp_pops[k]);
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      sdata[k] = '0; force_len[k] = '0; pop_cnt[k] = 0; exp_pops[k] = 0;
    end
    #1;
    reset_dut();

    // Directed frame on channel 4.
    rdy_prob = 100;
    load(4, 1, 1'b0, 8'h01);
    load(4, 1, 1'b0, 8'h02);
    load(4, 1, 1'b0, 8'h03);
    exp_q.push_back(8'h55); exp_q.push_back(8'h14); exp_q.push_back(8'h03);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    exp_q.push_back(8'h1D);
    exp_pops[4] += 3;
    rr_m = 0;
    update_bus();
    drain(200);

    // All channels held pending with len 1: two full round-robin laps.
    for (int k = 0; k < NUM_CH; k++) begin
      load(k, 2, 1'b1, 8'h00);
      force_len[k] = 8'd1;
    end
    force_len_en = '1;
    update_bus();
    model_drain();
    drain(500);
    force_len_en = '0;
    update_bus();

    // Random channel mixes with random back-pressure.
    for (int r = 0; r < 12; r++) begin
      int mask;
      rdy_prob = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 70 : 35);
      mask = $urandom_range(31, 1);
      for (int k = 0; k < NUM_CH; k++)
        if (mask[k]) load(k, $urandom_range(12, 1), 1'b1, 8'h00);
      update_bus();
      model_drain();
      drain(6000);
    end

    // Zero-length pending channel is skipped.
    reset_dut();
    rdy_prob      = 80;
    force_have[2] = 1'b1;
    force_len_en[2] = 1'b1;
    force_len[2]  = 8'd0;
    load(3, 2, 1'b1, 8'h00);
    update_bus();
    model_drain();
    drain(300);

    // Maximum length packet.
    reset_dut();
    rdy_prob = 100;
    load(2, 255, 1'b0, 8'hFF);
    update_bus();
    model_drain();
    drain(2000);

    // Reset after two payload bytes, then a complete packet.
    begin
      int cyc;
      rdy_prob = 100;
      load(1, 6, 1'b1, 8'h00);
      exp_q.push_back(8'h55); exp_q.push_back(8'h11); exp_q.push_back(8'h06);
      exp_q.push_back(fifo[1][0]); exp_q.push_back(fifo[1][1]);
      update_bus();
      cyc = 0;
      while (rd_idx != exp_q.size() && cyc < 100) begin
        tick();
        cyc++;
      end
      check("reset_point_reached", rd_idx, exp_q.size());
      reset_dut();
      rdy_prob = 60;
      load(3, 4, 1'b1, 8'h00);
      update_bus();
      model_drain();
      drain(500);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
